// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control unit: FETCH/DECODE/EXEC/MEM/WB FSM with a MULT stall,
// a memory wait timeout that traps, and a retired-instruction counter.
module mc_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int HAS_MULT    = 1,
  parameter int MULT_CYC    = 32,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      ins,
  input  logic             mem_ready,
  input  logic             zero,
  output logic             pcWr,
  output logic             irWr,
  output logic             memRd,
  output logic             memWr,
  output logic             regWr,
  output logic [1:0]       pcSrc,
  output logic [3:0]       aluCtr,
  output logic [1:0]       aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic [1:0]       regDst,
  output logic [1:0]       memtoReg,
  output logic [1:0]       immExt,
  output logic [1:0]       byteExt,
  output logic [2:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3,
    S_WB = 3'd4, S_MULW = 3'd5, S_TRAP = 3'd6
  } state_e;

  typedef enum logic [2:0] {K_ALU, K_LOAD, K_STORE, K_BR, K_J, K_JR, K_MULT} kind_e;

  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010,
                         ALU_OR  = 4'b0011, ALU_NOR = 4'b0100, ALU_XOR = 4'b0101,
                         ALU_SLL = 4'b0110, ALU_SRL = 4'b0111, ALU_SRA = 4'b1000,
                         ALU_MUL = 4'b1001, ALU_SLTU = 4'b1010, ALU_SLT = 4'b1011;

  localparam int               MUL_W     = (MULT_CYC > 1) ? $clog2(MULT_CYC) : 1;
  localparam logic [MUL_W-1:0] MUL_LOAD  = MUL_W'(MULT_CYC - 1);
  localparam logic [7:0]       WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [31:0]        ir_q, ir_d;
  logic [7:0]         wait_q, wait_d;
  logic [MUL_W-1:0]   mul_q, mul_d;
  logic               illegal_q, illegal_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               pc_wr, ir_wr, mem_rd, mem_wr, reg_wr;

  logic [5:0] op, fn;
  logic       legal, is_r, link, shift_imm, is_bne;
  kind_e      kind;
  logic [3:0] alu_op;
  logic [1:0] imm_ext, byte_ext;

  assign op = ir_q[31:26];
  assign fn = ir_q[5:0];

  // Register fields are consumed by the datapath, not by this controller.
  logic unused_ir;
  assign unused_ir = ^ir_q[25:6];

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    legal     = 1'b1;
    is_r      = 1'b0;
    link      = 1'b0;
    shift_imm = 1'b0;
    is_bne    = 1'b0;
    kind      = K_ALU;
    alu_op    = ALU_ADD;
    imm_ext   = 2'b00;
    byte_ext  = 2'b00;
    case (op)
      6'h00: begin
        is_r = 1'b1;
        case (fn)
          6'h20, 6'h21: alu_op = ALU_ADD;
          6'h22, 6'h23: alu_op = ALU_SUB;
          6'h24:        alu_op = ALU_AND;
          6'h25:        alu_op = ALU_OR;
          6'h26:        alu_op = ALU_XOR;
          6'h27:        alu_op = ALU_NOR;
          6'h2A:        alu_op = ALU_SLT;
          6'h2B:        alu_op = ALU_SLTU;
          6'h00:        begin alu_op = ALU_SLL; shift_imm = 1'b1; end
          6'h02:        begin alu_op = ALU_SRL; shift_imm = 1'b1; end
          6'h03:        begin alu_op = ALU_SRA; shift_imm = 1'b1; end
          6'h04:        alu_op = ALU_SLL;
          6'h06:        alu_op = ALU_SRL;
          6'h07:        alu_op = ALU_SRA;
          6'h08:        kind = K_JR;
          6'h09:        begin kind = K_JR; link = 1'b1; end
          6'h18:        begin kind = K_MULT; alu_op = ALU_MUL; legal = (HAS_MULT != 0); end
          default:      legal = 1'b0;
        endcase
      end
      6'h09: alu_op = ALU_ADD;
      6'h0A: begin alu_op = ALU_SLT; imm_ext = 2'b01; end
      6'h0B: alu_op = ALU_SLTU;
      6'h0C: alu_op = ALU_AND;
      6'h0D: alu_op = ALU_OR;
      6'h0E: alu_op = ALU_XOR;
      6'h0F: imm_ext = 2'b10;
      6'h23: begin kind = K_LOAD; imm_ext = 2'b01; byte_ext = 2'b11; end
      6'h20: begin kind = K_LOAD; imm_ext = 2'b01; byte_ext = 2'b01; end
      6'h24: begin kind = K_LOAD; imm_ext = 2'b01; end
      6'h2B, 6'h28: begin kind = K_STORE; imm_ext = 2'b01; end
      6'h04: begin kind = K_BR; alu_op = ALU_SUB; imm_ext = 2'b01; end
      6'h05: begin kind = K_BR; alu_op = ALU_SUB; imm_ext = 2'b01; is_bne = 1'b1; end
      6'h02: kind = K_J;
      6'h03: begin kind = K_J; link = 1'b1; end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    wait_d    = '0;
    mul_d     = mul_q;
    retired_d = retired_q;
    pc_wr = 1'b0; ir_wr = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; reg_wr = 1'b0;
    pcSrc = 2'b00; aluCtr = 4'b0000; aluSrcA = 2'b00; aluSrcB = 2'b00;
    regDst = 2'b00; memtoReg = 2'b00; immExt = 2'b00; byteExt = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        aluCtr  = alu_op;
        aluSrcA = shift_imm ? 2'b01 : 2'b00;
        // Branches compare rs with rt, so only immediate ALU ops and address calc take the immediate.
        aluSrcB = (!is_r && (kind == K_ALU || kind == K_LOAD || kind == K_STORE)) ? 2'b01 : 2'b00;
        immExt  = imm_ext;
        case (kind)
          K_ALU:           state_d = S_WB;
          K_LOAD, K_STORE: state_d = S_MEM;
          K_BR: begin
            pc_wr   = is_bne ? ~zero : zero;
            pcSrc   = 2'b01;
            state_d = S_FETCH;
          end
          K_J: begin
            pc_wr   = 1'b1;
            pcSrc   = 2'b10;
            state_d = link ? S_WB : S_FETCH;
          end
          K_JR: begin
            pc_wr   = 1'b1;
            pcSrc   = 2'b11;
            state_d = link ? S_WB : S_FETCH;
          end
          K_MULT: begin
            mul_d   = MUL_LOAD;
            state_d = S_MULW;
          end
          default: state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        mem_rd  = (kind == K_LOAD);
        mem_wr  = (kind == K_STORE);
        byteExt = (kind == K_LOAD) ? byte_ext : 2'b00;
        if (mem_ready) state_d = (kind == K_LOAD) ? S_WB : S_FETCH;
      end
      S_WB: begin
        reg_wr   = 1'b1;
        regDst   = is_r ? 2'b01 : ((kind == K_J && link) ? 2'b10 : 2'b00);
        memtoReg = (kind == K_LOAD) ? 2'b01 : (link ? 2'b10 : 2'b00);
        byteExt  = (kind == K_LOAD) ? byte_ext : 2'b00;
        state_d  = S_FETCH;
      end
      S_MULW: begin
        if (mul_q == '0) state_d = S_FETCH;
        else             mul_d   = mul_q - 1'b1;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase

    // A memory wait that reaches its limit traps unless mem_ready arrives in that same cycle.
    if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready) begin
      if (wait_q == WAIT_LAST) state_d = S_TRAP;
      else                     wait_d  = wait_q + 8'd1;
    end

    if (ir_wr) ir_d = ins;
    if (state_d == S_FETCH && state_q inside {S_EXEC, S_MEM, S_WB, S_MULW})
      retired_d = retired_q + CNT_W'(1);
    illegal_d = illegal_q | (state_d == S_TRAP);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the instruction register is reset too, so decode never acts on stale contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      wait_q    <= '0;
      mul_q     <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      wait_q    <= wait_d;
      mul_q     <= mul_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  // Strobes are held low for as long as reset is asserted.
  assign pcWr    = pc_wr  & rst_n;
  assign irWr    = ir_wr  & rst_n;
  assign memRd   = mem_rd & rst_n;
  assign memWr   = mem_wr & rst_n;
  assign regWr   = reg_wr & rst_n;
  assign state   = state_q;
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule
